// File: rtl/attn_dot_score.sv
// Streaming signed dot product of NFEAT interleaved Q/K pairs, scaled by >>>SHIFT and saturated to OUT_W.
// Latency: score valid the cycle after the last k beat is accepted; one score per 2*NFEAT accepted beats.
// Backpressure: holds the score while out_rdy=0 and stalls input; an output handshake can overlap the next q0.
module attn_dot_score #(
   parameter int DATA_W = 8,
   parameter int NFEAT  = 4,
   parameter int SHIFT  = 9,
   parameter int OUT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_vld,
   output logic              in_rdy,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic              out_sat
);

   // Accumulator is sized so NFEAT full-precision products can never overflow it.
   localparam int ACC_W  = 2*DATA_W + $clog2(NFEAT);
   localparam int PROD_W = 2*DATA_W;
   localparam int CNT_W  = $clog2(NFEAT);
   localparam logic [CNT_W-1:0] L_LAST = CNT_W'(NFEAT-1);
   localparam logic signed [ACC_W-1:0] L_SMAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
   // Two's complement: ~max == -max-1 == most negative OUT_W value.
   localparam logic signed [ACC_W-1:0] L_SMIN = ~L_SMAX;

   typedef enum logic [1:0] {
      Q_BEAT = 2'd0,
      K_BEAT = 2'd1,
      OUT    = 2'd2
   } state_t;

   state_t                   r_state;
   logic [CNT_W-1:0]         r_feat_cnt;
   logic signed [ACC_W-1:0]  r_acc;
   logic [DATA_W-1:0]        r_q;
   logic [OUT_W-1:0]         r_out_data;
   logic                     r_out_vld;
   logic                     r_out_sat;

   logic signed [PROD_W-1:0] w_prod;
   logic signed [ACC_W-1:0]  w_sum;
   logic signed [ACC_W-1:0]  w_scaled;
   logic                     w_hi;
   logic                     w_lo;
   logic [OUT_W-1:0]         w_sat_data;
   logic                     w_in_fire;

   // Product, running sum and the scaled/saturated view of the sum, used on the final k beat.
   always_comb begin
      w_prod     = $signed(r_q) * $signed(in_data);
      w_sum      = r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
      w_scaled   = w_sum >>> SHIFT;
      w_hi       = (w_scaled > L_SMAX);
      w_lo       = (w_scaled < L_SMIN);
      w_sat_data = w_hi ? L_SMAX[OUT_W-1:0] :
                   w_lo ? L_SMIN[OUT_W-1:0] : w_scaled[OUT_W-1:0];
   end

   // Input is ready unless a score is stuck waiting downstream; clear blocks all transfers.
   always_comb begin
      in_rdy    = ((r_state != OUT) || out_rdy) && !clear;
      w_in_fire = in_vld && in_rdy;
   end

   // Beat-sequencing FSM with registered score outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= Q_BEAT;
         r_feat_cnt <= '0;
         r_acc      <= '0;
         r_q        <= '0;
         r_out_data <= '0;
         r_out_vld  <= 1'b0;
         r_out_sat  <= 1'b0;
      end else if (clear) begin
         // Abort: drop partial vector and any pending score; out_data keeps its last value.
         r_state    <= Q_BEAT;
         r_feat_cnt <= '0;
         r_acc      <= '0;
         r_out_vld  <= 1'b0;
         r_out_sat  <= 1'b0;
      end else begin
         case (r_state)
            Q_BEAT: begin
               if (w_in_fire) begin
                  r_q     <= in_data;
                  r_state <= K_BEAT;
               end
            end
            K_BEAT: begin
               if (w_in_fire) begin
                  r_acc <= w_sum;
                  if (r_feat_cnt == L_LAST) begin
                     r_feat_cnt <= '0;
                     r_state    <= OUT;
                     r_out_vld  <= 1'b1;
                     r_out_data <= w_sat_data;
                     r_out_sat  <= w_hi || w_lo;
                  end else begin
                     r_feat_cnt <= r_feat_cnt + CNT_W'(1);
                     r_state    <= Q_BEAT;
                  end
               end
            end
            OUT: begin
               if (out_rdy) begin
                  r_out_vld <= 1'b0;
                  r_acc     <= '0;
                  // A beat in the handshake cycle is q0 of the next vector: no bubble.
                  if (in_vld) begin
                     r_q     <= in_data;
                     r_state <= K_BEAT;
                  end else begin
                     r_state <= Q_BEAT;
                  end
               end
            end
            default: begin
               r_state <= Q_BEAT;
            end
         endcase
      end
   end

   assign out_data = r_out_data;
   assign out_vld  = r_out_vld;
   assign out_sat  = r_out_sat;

endmodule

// File: tb/tb_attn_dot_score.sv
// Scoreboard bench for attn_dot_score: directed scenarios plus randomized vectors.
// Expected scores come from an integer dot-product model pushed into a queue at stimulus time.
// A monitor pops and compares on every output handshake.
module tb_attn_dot_score;

   localparam int DATA_W = 8;
   localparam int NFEAT  = 4;
   localparam int SHIFT  = 9;
   localparam int OUT_W  = 8;

   logic              clk;
   logic              rst_n;
   logic              clear;
   logic [DATA_W-1:0] in_data;
   logic              in_vld;
   logic              in_rdy;
   logic [OUT_W-1:0]  out_data;
   logic              out_vld;
   logic              out_rdy;
   logic              out_sat;

   int n_pass  = 0;
   int n_total = 0;
   int exp_q[$];
   bit rand_rdy = 1'b0;

   attn_dot_score #(
      .DATA_W(DATA_W), .NFEAT(NFEAT), .SHIFT(SHIFT), .OUT_W(OUT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
      .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_sat(out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference: exact integer dot product, floor-shift, clip. Packs {sat, data}.
   function automatic int model(input logic [NFEAT*DATA_W-1:0] qv, input logic [NFEAT*DATA_W-1:0] kv);
      int dot;
      int s;
      logic [DATA_W-1:0] qb;
      logic [DATA_W-1:0] kb;
      dot = 0;
      for (int i = 0; i < NFEAT; i++) begin
         qb = qv[i*DATA_W +: DATA_W];
         kb = kv[i*DATA_W +: DATA_W];
         dot += int'($signed(qb)) * int'($signed(kb));
      end
      s = dot >>> SHIFT;
      if (s > 127)       return 32'h100 | 127;
      else if (s < -128) return 32'h100 | 128;
      else               return s & 32'hFF;
   endfunction

   task automatic wiggle_rdy();
      if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
   endtask

   task automatic summary_and_fatal(input string why);
      $display("FAIL %s: bound expired at %0t", why, $time);
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1, "bench aborted");
   endtask

   // Called at a negedge; returns at the negedge after the beat was accepted.
   task automatic send_beat(input logic [DATA_W-1:0] d);
      int n;
      n = 0;
      in_data = d;
      in_vld  = 1'b1;
      #1;
      while (!in_rdy) begin
         @(negedge clk);
         wiggle_rdy();
         #1;
         n++;
         if (n > 2000) summary_and_fatal("beat_accept");
      end
      @(negedge clk);
      in_vld = 1'b0;
      wiggle_rdy();
   endtask

   task automatic idle(input int n);
      in_vld = 1'b0;
      repeat (n) begin
         @(negedge clk);
         wiggle_rdy();
      end
   endtask

   task automatic send_vector(input logic [NFEAT*DATA_W-1:0] qv, input logic [NFEAT*DATA_W-1:0] kv,
                              input int gap);
      for (int i = 0; i < NFEAT; i++) begin
         send_beat(qv[i*DATA_W +: DATA_W]);
         idle(gap);
         send_beat(kv[i*DATA_W +: DATA_W]);
         if (i != NFEAT-1) idle(gap);
      end
      exp_q.push_back(model(qv, kv));
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_rdy = 1'b1;
      in_vld  = 1'b0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain_queue_empty", exp_q.size(), 0);
   endtask

   // Monitor: compares every output handshake against the scoreboard head.
   initial begin
      int e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("score_data", int'(out_data), e & 32'hFF);
               chk("score_sat", int'(out_sat), (e >> 8) & 1);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NFEAT*DATA_W-1:0] qa;
      logic [NFEAT*DATA_W-1:0] ka;
      logic [NFEAT*DATA_W-1:0] qb;
      logic [NFEAT*DATA_W-1:0] kb;
      int ea;

      rst_n = 1'b0; clear = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_out_vld", int'(out_vld), 0);
      chk("reset_out_data", int'(out_data), 0);
      chk("reset_out_sat", int'(out_sat), 0);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("reset_in_rdy", int'(in_rdy), 1);
      @(negedge clk);

      // Scenario 1: 0x40*0x40 x4 -> 0x20, with latency / pulse-width checks.
      send_vector({4{8'h40}}, {4{8'h40}}, 0);
      #1;
      chk("s1_out_vld_rise", int'(out_vld), 1);
      @(negedge clk);
      #1;
      chk("s1_out_vld_one_cycle", int'(out_vld), 0);
      @(negedge clk);

      // Scenario 2 and 3: positive saturation and exact -127.
      send_vector({4{8'h80}}, {4{8'h80}}, 0);
      send_vector({4{8'h7F}}, {4{8'h80}}, 0);
      drain();

      // Backpressure: hold result 5 cycles, then overlap handshake with next q0.
      qa = {8'h10, 8'hF0, 8'h33, 8'h7F};
      ka = {8'h22, 8'h90, 8'hC5, 8'h41};
      qb = {8'h80, 8'h05, 8'hEE, 8'h19};
      kb = {8'h7F, 8'h66, 8'h12, 8'hA3};
      ea = model(qa, ka);
      out_rdy = 1'b0;
      send_vector(qa, ka, 0);
      in_data = qb[DATA_W-1:0];
      in_vld  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_out_vld_held", int'(out_vld), 1);
         chk("bp_out_data_stable", int'(out_data), ea & 32'hFF);
         chk("bp_in_rdy_low", int'(in_rdy), 0);
         @(negedge clk);
      end
      out_rdy = 1'b1;
      send_beat(qb[DATA_W-1:0]);
      #1;
      chk("bp_handshake_with_q0", int'(out_vld), 0);
      @(negedge clk);
      send_beat(kb[DATA_W-1:0]);
      for (int i = 1; i < NFEAT; i++) begin
         send_beat(qb[i*DATA_W +: DATA_W]);
         send_beat(kb[i*DATA_W +: DATA_W]);
      end
      exp_q.push_back(model(qb, kb));
      drain();

      // in_vld every other cycle gives the same score.
      send_vector({4{8'h40}}, {4{8'h40}}, 1);
      drain();

      // Clear after 3 beats aborts the partial vector.
      send_beat(8'h7F);
      send_beat(8'h7F);
      send_beat(8'h7F);
      clear = 1'b1; in_vld = 1'b1; in_data = 8'h55;
      #1;
      chk("clear_blocks_in_rdy", int'(in_rdy), 0);
      @(negedge clk);
      clear = 1'b0; in_vld = 1'b0;
      @(negedge clk);
      send_vector({4{8'h40}}, {4{8'h40}}, 0);
      drain();

      // Reset after 5 beats: no stale output afterwards.
      for (int i = 0; i < 5; i++) send_beat(8'h80);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      chk("mid_reset_out_vld", int'(out_vld), 0);
      chk("mid_reset_out_data", int'(out_data), 0);
      chk("mid_reset_out_sat", int'(out_sat), 0);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("mid_reset_in_rdy", int'(in_rdy), 1);
      repeat (4) @(negedge clk);
      #1;
      chk("mid_reset_no_stale", int'(out_vld), 0);
      @(negedge clk);

      // Randomized vectors with random gaps and random downstream stalls.
      rand_rdy = 1'b1;
      for (int v = 0; v < 25; v++) begin
         for (int i = 0; i < NFEAT; i++) begin
            case ($urandom_range(0, 7))
               0:       begin qa[i*DATA_W +: DATA_W] = 8'h80; ka[i*DATA_W +: DATA_W] = 8'h80; end
               1:       begin qa[i*DATA_W +: DATA_W] = 8'h7F; ka[i*DATA_W +: DATA_W] = 8'h80; end
               default: begin
                  qa[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                  ka[i*DATA_W +: DATA_W] = DATA_W'($urandom);
               end
            endcase
         end
         send_vector(qa, ka, $urandom_range(0, 1));
      end
      rand_rdy = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
